// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the ALU command sequencer and its environment:
// program load, run control, ALU operand/opcode buses and the result stream.
interface alu_cmd_sequencer_if #(
   parameter int PA_W = 4
);
   logic            prog_we;
   logic [PA_W-1:0] prog_addr;
   logic [11:0]     prog_data;
   logic [PA_W:0]   prog_len;
   logic            start;
   logic            busy;
   logic            done;
   logic [7:0]      alu_ui;
   logic [7:0]      alu_uio;
   logic [7:0]      alu_uo;
   logic            res_valid;
   logic            res_ready;
   logic [7:0]      res_data;
   logic [PA_W-1:0] res_idx;

   modport master (
      input  prog_we, prog_addr, prog_data, prog_len, start, alu_uo, res_ready,
      output busy, done, alu_ui, alu_uio, res_valid, res_data, res_idx
   );

   modport slave (
      output prog_we, prog_addr, prog_data, prog_len, start, alu_uo, res_ready,
      input  busy, done, alu_ui, alu_uio, res_valid, res_data, res_idx
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues a stored program of ALU commands back-to-back, captures each tagged
// ALU result after the fixed ALU latency and streams results in program order.
module alu_cmd_sequencer #(
   parameter int PROG_DEPTH = 16,
   parameter int RES_DEPTH  = 4,
   parameter int ALU_LAT    = 2
) (
   input logic                 clk,
   input logic                 rst,
   alu_cmd_sequencer_if.master bus
);
   localparam int PA_W   = $clog2(PROG_DEPTH);
   localparam int RA_W   = $clog2(RES_DEPTH);
   localparam int PIPE_D = ALU_LAT + 1;
   localparam int CNT_W  = $clog2(RES_DEPTH + PIPE_D + 1);
   localparam logic [7:0] NOP_UIO = 8'h0F;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e          state_q;
   logic [PA_W-1:0] pc_q;
   logic [PA_W:0]   len_q;
   logic [7:0]      alu_ui_q;
   logic [7:0]      alu_uio_q;
   logic            done_q;
   logic [PIPE_D-1:0] pipe_v_q;
   logic [PA_W-1:0]   pipe_tag_q [PIPE_D];

   logic [11:0]     prog_mem  [PROG_DEPTH];
   logic [7:0]      fifo_data [RES_DEPTH];
   logic [PA_W-1:0] fifo_tag  [RES_DEPTH];
   logic [RA_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [RA_W:0]   count_q, count_d;

   logic [CNT_W-1:0] inflight;
   logic             credit, issue, push, pop;

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_D; i++) begin
         inflight = inflight + CNT_W'(pipe_v_q[i]);
      end
      credit   = (CNT_W'(count_q) + inflight) < CNT_W'(RES_DEPTH);
      issue    = (state_q == RUN) && credit;
      push     = pipe_v_q[PIPE_D-1];
      pop      = (count_q != '0) && bus.res_ready;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         len_q     <= '0;
         alu_ui_q  <= 8'h00;
         alu_uio_q <= NOP_UIO;
         done_q    <= 1'b0;
         pipe_v_q  <= '0;
         for (int i = 0; i < PIPE_D; i++) begin
            pipe_tag_q[i] <= '0;
         end
      end else begin
         done_q    <= 1'b0;
         alu_ui_q  <= 8'h00;
         alu_uio_q <= NOP_UIO;
         pipe_v_q  <= {pipe_v_q[PIPE_D-2:0], issue};
         pipe_tag_q[0] <= pc_q;
         for (int i = 1; i < PIPE_D; i++) begin
            pipe_tag_q[i] <= pipe_tag_q[i-1];
         end
         case (state_q)
            IDLE: begin
               if (bus.start && bus.prog_len != '0) begin
                  len_q   <= bus.prog_len;
                  pc_q    <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (credit) begin
                  alu_ui_q  <= prog_mem[pc_q][7:0];
                  alu_uio_q <= {4'b0000, prog_mem[pc_q][11:8]};
                  pc_q      <= pc_q + 1'b1;
                  if ({1'b0, pc_q} == len_q - 1'b1) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pipe_v_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: storage arrays carry no reset; validity is tracked by state, pointers and count.
   always_ff @(posedge clk) begin
      if (bus.prog_we && state_q == IDLE) begin
         prog_mem[bus.prog_addr] <= bus.prog_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr_q] <= bus.alu_uo;
         fifo_tag[wr_ptr_q]  <= pipe_tag_q[PIPE_D-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.alu_ui    = alu_ui_q;
   assign bus.alu_uio   = alu_uio_q;
   assign bus.res_valid = (count_q != '0);
   // Head is masked while empty so the unreset storage never shows on the bus.
   assign bus.res_data  = bus.res_valid ? fifo_data[rd_ptr_q] : 8'h00;
   assign bus.res_idx   = bus.res_valid ? fifo_tag[rd_ptr_q] : '0;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a behavioural 4-bit ALU on the bus, directed
// scenarios, randomized programs and a scoreboard fed in program order.
module tb_alu_cmd_sequencer;
   localparam int PA_W = 4;
   localparam int PROG_DEPTH = 16;

   typedef struct {
      logic [7:0] data;
      logic [3:0] idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_cmd_sequencer_if #(.PA_W(PA_W)) bus_if ();

   alu_cmd_sequencer #(
      .PROG_DEPTH(PROG_DEPTH),
      .RES_DEPTH (4),
      .ALU_LAT   (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   issue_cnt = 0;
   int   ready_mode = 0;
   exp_t exp_q[$];
   logic [11:0] shadow [PROG_DEPTH];
   logic [3:0]  ref_regs [16];
   logic [3:0]  alu_regs [16];
   logic [7:0]  alu_s1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ALU semantics: {Z, S, V, C, result}; SUB carry is the borrow.
   function automatic logic [7:0] alu_eval(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] rv);
      logic [4:0] s;
      logic [3:0] r;
      logic       c, v;
      s = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0;
      case (op)
         4'h0: begin
            s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
            v = (a[3] == b[3]) && (r[3] != a[3]);
         end
         4'h1: begin
            s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
            v = (a[3] != b[3]) && (r[3] != a[3]);
         end
         4'h9: r = rv;
         default: r = 4'd0;
      endcase
      return {(r == 4'd0), r[3], v, c, r};
   endfunction

   // Environment ALU: operand stage then output stage.
   initial begin
      for (int i = 0; i < 16; i++) begin
         alu_regs[i] = 4'd0;
         ref_regs[i] = 4'd0;
      end
      alu_s1 = 8'h00;
      bus_if.alu_uo = 8'h00;
   end

   always @(posedge clk) begin
      if (bus_if.alu_uio[3:0] == 4'h8) alu_regs[bus_if.alu_ui[7:4]] <= bus_if.alu_ui[3:0];
      if (bus_if.alu_uio[3:0] != 4'hF)
         alu_s1 <= alu_eval(bus_if.alu_uio[3:0], bus_if.alu_ui[3:0], bus_if.alu_ui[7:4],
                            alu_regs[bus_if.alu_ui[7:4]]);
      bus_if.alu_uo <= alu_s1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus_if.res_ready = 1'b0;
      forever begin
         tick();
         case (ready_mode)
            0: bus_if.res_ready = 1'b0;
            1: bus_if.res_ready = 1'b1;
            default: bus_if.res_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: scoreboard pops, head stability, done and issue counting.
   initial begin
      logic        hold_v;
      logic [11:0] hold_val;
      exp_t        e;
      hold_v = 1'b0;
      hold_val = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_v = 1'b0;
         end else begin
            if (bus_if.done) done_cnt++;
            if (bus_if.alu_uio[3:0] != 4'hF) issue_cnt++;
            if (hold_v && bus_if.res_valid)
               check("res_hold", {bus_if.res_idx, bus_if.res_data}, hold_val);
            if (bus_if.res_valid && bus_if.res_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got %0h idx %0d with nothing expected",
                           bus_if.res_data, bus_if.res_idx);
               end else begin
                  e = exp_q.pop_front();
                  check("res_data", bus_if.res_data, e.data);
                  check("res_idx", bus_if.res_idx, e.idx);
               end
            end
            hold_v   = bus_if.res_valid && !bus_if.res_ready;
            hold_val = {bus_if.res_idx, bus_if.res_data};
         end
      end
   end

   task automatic prog_write(input int addr, input logic [11:0] data);
      bus_if.prog_we   = 1'b1;
      bus_if.prog_addr = 4'(addr);
      bus_if.prog_data = data;
      shadow[addr]     = data;
      tick();
      bus_if.prog_we   = 1'b0;
   endtask

   task automatic model_entry(input logic [11:0] e, output logic [7:0] r);
      r = alu_eval(e[11:8], e[3:0], e[7:4], ref_regs[e[7:4]]);
      if (e[11:8] == 4'h8) ref_regs[e[7:4]] = e[3:0];
   endtask

   task automatic push_lit(input logic [7:0] d, input int i);
      exp_q.push_back('{data: d, idx: 4'(i)});
   endtask

   task automatic start_run(input int len, input bit use_model);
      logic [7:0] r;
      for (int i = 0; i < len; i++) begin
         model_entry(shadow[i], r);
         if (use_model) exp_q.push_back('{data: r, idx: 4'(i)});
      end
      bus_if.prog_len = 5'(len);
      bus_if.start    = 1'b1;
      tick();
      bus_if.start    = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int bound);
      int n;
      n = 0;
      while (done_cnt == d0 && n < bound) begin
         tick();
         n++;
      end
      if (done_cnt == d0) check("done_timeout", 32'(done_cnt - d0), 1);
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus_if.res_valid) && n < bound) begin
         tick();
         n++;
      end
      if (n >= bound) check("drain_timeout", 32'(exp_q.size()), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, i0;
      rst = 1'b1;
      bus_if.prog_we = 1'b0;
      bus_if.prog_addr = '0;
      bus_if.prog_data = '0;
      bus_if.prog_len = '0;
      bus_if.start = 1'b0;
      for (int i = 0; i < PROG_DEPTH; i++) shadow[i] = 12'h000;
      tick();
      tick();
      check("rst_busy", bus_if.busy, 1'b0);
      check("rst_done", bus_if.done, 1'b0);
      check("rst_alu_ui", bus_if.alu_ui, 8'h00);
      check("rst_alu_uio", bus_if.alu_uio, 8'h0F);
      check("rst_res_valid", bus_if.res_valid, 1'b0);
      check("rst_res_data", bus_if.res_data, 8'h00);
      check("rst_res_idx", bus_if.res_idx, 4'h0);
      rst = 1'b0;
      tick();

      // Single ADD with exact issue and capture timing.
      ready_mode = 1;
      prog_write(0, 12'h043);
      d0 = done_cnt; i0 = issue_cnt;
      push_lit(8'h07, 0);
      start_run(1, 1'b0);
      tick();
      check("t1_alu_uio", bus_if.alu_uio, 8'h00);
      check("t1_alu_ui", bus_if.alu_ui, 8'h43);
      tick(); tick(); tick();
      check("t1_res_valid", bus_if.res_valid, 1'b1);
      check("t1_res_data", bus_if.res_data, 8'h07);
      check("t1_res_idx", bus_if.res_idx, 4'h0);
      wait_done(d0, 50);
      tick(); tick();
      check("t1_done_pulses", 32'(done_cnt - d0), 1);
      check("t1_issued", 32'(issue_cnt - i0), 1);

      // SUB borrow/sign, ADD overflow.
      prog_write(0, 12'h110);
      prog_write(1, 12'h017);
      d0 = done_cnt;
      push_lit(8'h5F, 0);
      push_lit(8'h68, 1);
      start_run(2, 1'b0);
      wait_done(d0, 50);
      wait_drain(50);
      check("t2_done_pulses", 32'(done_cnt - d0), 1);

      // Back-to-back register write then read.
      prog_write(0, 12'h829);
      prog_write(1, 12'h920);
      d0 = done_cnt;
      push_lit(8'h80, 0);
      push_lit(8'h49, 1);
      start_run(2, 1'b0);
      wait_done(d0, 50);
      wait_drain(50);

      // Credit backpressure with a stalled consumer.
      for (int i = 0; i < 8; i++) prog_write(i, {8'h00, 4'(i)});
      ready_mode = 0;
      tick(); tick();
      d0 = done_cnt; i0 = issue_cnt;
      for (int i = 0; i < 8; i++) push_lit((i == 0) ? 8'h80 : 8'(i), i);
      start_run(8, 1'b0);
      for (int i = 0; i < 14; i++) tick();
      check("t4_issued_stalled", 32'(issue_cnt - i0), 4);
      check("t4_busy", bus_if.busy, 1'b1);
      check("t4_alu_uio_nop", bus_if.alu_uio, 8'h0F);
      check("t4_res_valid", bus_if.res_valid, 1'b1);
      check("t4_head_data", bus_if.res_data, 8'h80);
      check("t4_no_done", 32'(done_cnt - d0), 0);
      ready_mode = 1;
      wait_done(d0, 100);
      wait_drain(50);
      check("t4_issued_total", 32'(issue_cnt - i0), 8);
      check("t4_done_pulses", 32'(done_cnt - d0), 1);

      // Reset mid-run with two commands in flight, then a clean rerun.
      d0 = done_cnt;
      start_run(8, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("t5_async_busy", bus_if.busy, 1'b0);
      tick();
      check("t5_res_valid", bus_if.res_valid, 1'b0);
      check("t5_busy", bus_if.busy, 1'b0);
      check("t5_alu_uio", bus_if.alu_uio, 8'h0F);
      check("t5_no_done", 32'(done_cnt - d0), 0);
      exp_q.delete();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) push_lit((i == 0) ? 8'h80 : 8'(i), i);
      start_run(8, 1'b0);
      wait_done(d0, 100);
      wait_drain(50);

      // Zero-length start, and start/prog_we while busy.
      d0 = done_cnt; i0 = issue_cnt;
      start_run(0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      check("t6_len0_busy", bus_if.busy, 1'b0);
      check("t6_len0_issued", 32'(issue_cnt - i0), 0);
      check("t6_len0_done", 32'(done_cnt - d0), 0);
      for (int i = 0; i < 4; i++) push_lit((i == 0) ? 8'h80 : 8'(i), i);
      start_run(4, 1'b0);
      bus_if.prog_we = 1'b1;
      bus_if.prog_addr = 4'd0;
      bus_if.prog_data = 12'h0FF;
      bus_if.prog_len = 5'd2;
      bus_if.start = 1'b1;
      tick();
      bus_if.prog_we = 1'b0;
      bus_if.start = 1'b0;
      wait_done(d0, 100);
      wait_drain(50);
      check("t6_busy_issued", 32'(issue_cnt - i0), 4);
      check("t6_busy_done", 32'(done_cnt - d0), 1);
      d0 = done_cnt;
      push_lit(8'h80, 0);
      start_run(1, 1'b0);
      wait_done(d0, 50);
      wait_drain(50);

      // Randomized programs; unread results carry over between runs.
      for (int i = 0; i < PROG_DEPTH; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 3));
         prog_write(i, {(op[1] ? {3'b100, op[0]} : {3'b000, op[0]}), 8'($urandom)});
      end
      for (int run = 0; run < 25; run++) begin
         int nw, len;
         nw = $urandom_range(0, 4);
         for (int w = 0; w < nw; w++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 3));
            prog_write($urandom_range(0, PROG_DEPTH - 1),
                       {(op[1] ? {3'b100, op[0]} : {3'b000, op[0]}), 8'($urandom)});
         end
         ready_mode = $urandom_range(1, 2);
         len = $urandom_range(1, PROG_DEPTH);
         d0 = done_cnt;
         start_run(len, 1'b1);
         wait_done(d0, 400);
         check("rand_done_pulses", 32'(done_cnt - d0), 1);
      end
      ready_mode = 1;
      wait_drain(200);
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the tiny 4-bit ALU interface.
- Holds a small program of ALU commands and issues them back-to-back onto the ALU operand/opcode buses.
- Tags each command and captures the ALU's registered {ZERO,SIGN,OVERFLOW,CARRY,result} byte after the fixed ALU latency.
- Delivers captured bytes in program order through a valid/ready result FIFO with credit-based issue backpressure.

Parameters:
- PROG_DEPTH, 16, number of program entries (power of 2); PA_W = log2(PROG_DEPTH).
- RES_DEPTH, 4, result FIFO depth (power of 2, >= 2).
- ALU_LAT, 2, ALU register stages from operands to uo_out (result/flag stage plus output stage).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  program write strobe; ignored while busy=1.
- prog_addr  in  PA_W  program write address.
- prog_data  in  12  entry {opcode[3:0], B[3:0], A[3:0]}.
- prog_len  in  PA_W+1  number of entries to run, 0..PROG_DEPTH; sampled on start.
- start  in  1  run request; accepted only in IDLE with prog_len != 0.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the last result has been captured.
- alu_ui  out  8  registered {B, A} to ALU ui_in.
- alu_uio  out  8  registered {4'b0000, opcode} to ALU uio.
- alu_uo  in  8  ALU uo_out {Z,S,V,C,result[3:0]}.
- res_valid  out  1  result FIFO non-empty.
- res_ready  in  1  consumer accepts the head entry when res_valid and res_ready are both high.
- res_data  out  8  captured alu_uo for the head entry.
- res_idx  out  PA_W  program index of the head entry.

Behaviour:
- Reset (async, any state including mid-run):
  - state=IDLE; busy=0, done=0; alu_ui=8'h00, alu_uio=8'h0F (NOP; the ALU default case writes no register).
  - pc=0, in-flight pipe cleared, FIFO emptied, res_valid=0, res_data=0, res_idx=0.
  - Program memory is not reset.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - prog_we writes prog_data to mem[prog_addr].
  - start && prog_len!=0 latches len and sets pc=0 -> RUN.
  - start with prog_len==0 is ignored; done stays 0.
- RUN, each cycle:
  - credit = (fifo_count + inflight_count) < RES_DEPTH, where inflight_count is the number of valid bits in the capture pipe.
  - If credit: register mem[pc] onto alu_ui/alu_uio, shift a valid bit tagged with pc into the pipe, pc++.
  - If no credit: drive NOP and shift an invalid bit.
  - Issuing entry len-1 -> DRAIN.
- DRAIN: drive NOP each cycle; when the pipe holds no valid bits and no capture is pending -> IDLE with done=1 for exactly one cycle.
- Latency:
  - A command registered on edge k is captured from alu_uo on edge k+ALU_LAT+1 (default k+3).
  - The capture pipe is ALU_LAT+1 deep; its tail valid bit pushes {alu_uo, tag} into the FIFO.
- Throughput: one command per cycle when credit allows. Back-to-back REG_WRITE then REG_READ of the same address is legal; the ALU commits the write one edge before the read is evaluated.
- FIFO:
  - Simultaneous push and pop is allowed, including when full (count unchanged).
  - Overflow is impossible by the credit rule.
  - Order equals program order.
  - res_data/res_idx are stable while res_valid && !res_ready.
- start during busy is ignored; prog_we during busy is ignored; mem is never modified mid-run.
- Wrap: pc counts 0..len-1 only, with no wrap within a run. A new run restarts at pc=0.
- FIFO contents left unread at done persist into the next run and still count against credit.

Test Plan:
- Program {op0 A=3 B=4}, len=1, res_ready=1 -> alu_uio=8'h00, alu_ui=8'h43 one cycle after start; 3 cycles later res_valid=1, res_data=8'h07, res_idx=0; done pulses once.
- Program [SUB A=0 B=1; ADD A=7 B=1], len=2, res_ready=1 -> results in order 8'h5F (idx 0) then 8'h68 (idx 1) on consecutive cycles.
- Program [op8 A=9 B=2; op9 A=0 B=2] issued back-to-back -> results 8'h80 then 8'h49.
- RES_DEPTH=4, len=8 of ADD A=i B=0, res_ready=0 -> exactly 4 commands issued, then NOPs and busy=1. Raising res_ready yields results 0x80, 0x01..0x07 with idx 0..7 in order; done after the 8th capture.
- Assert rst mid-RUN with 2 results in flight -> next cycle res_valid=0, busy=0, alu_uio=8'h0F. A new start of the same program reproduces the full result sequence.
- start with prog_len=0, and start/prog_we while busy -> no issue, no done, mem unchanged (read back by running the program).
